// File: rtl/mac_tx_frame_fifo_pkg.sv
// Shared MAC TX parameters, lane-word payload type and pointer-width helper
// for the frame-aware TX FIFO.
package mac_tx_frame_fifo_pkg;

    localparam int unsigned MAC_N_CHANNELS   = 4;
    localparam int unsigned MAC_W_BYTE       = 8;
    localparam int unsigned MAC_W_DATA       = MAC_N_CHANNELS * MAC_W_BYTE;
    localparam int unsigned N_MAC_TX_FIFO    = 16;
    localparam int unsigned MAC_AFULL_THRESH = 12;

    typedef struct packed {
        logic                      last;
        logic [MAC_N_CHANNELS-1:0] ctrl;
        logic [MAC_W_DATA-1:0]     data;
    } mac_lane_word_t;

    // Pointer width carries one extra wrap bit above the address bits.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mac_tx_frame_fifo_if.sv
// Write/read/status bundle between the MAC TX framer, the frame FIFO and the PCS encoder.
interface mac_tx_frame_fifo_if
    import mac_tx_frame_fifo_pkg::*;
#(
    parameter int unsigned N_CHANNELS = MAC_N_CHANNELS,
    parameter int unsigned W_BYTE     = MAC_W_BYTE,
    parameter int unsigned DEPTH      = N_MAC_TX_FIFO
);
    localparam int unsigned PW = ptr_width(DEPTH);

    logic                         i_wen;
    logic                         i_wlast;
    logic                         i_wabort;
    logic [N_CHANNELS-1:0]        i_wctrl;
    logic [N_CHANNELS*W_BYTE-1:0] i_wdata;
    logic                         i_ren;
    logic [N_CHANNELS-1:0]        o_rctrl;
    logic [N_CHANNELS*W_BYTE-1:0] o_rdata;
    logic                         o_rlast;
    logic                         o_empty;
    logic                         o_full;
    logic                         o_afull;
    logic [PW-1:0]                o_level;
    logic                         o_overflow;
    logic                         o_underflow;

    modport master (
        output i_wen, i_wlast, i_wabort, i_wctrl, i_wdata, i_ren,
        input  o_rctrl, o_rdata, o_rlast, o_empty, o_full, o_afull,
               o_level, o_overflow, o_underflow
    );

    modport slave (
        input  i_wen, i_wlast, i_wabort, i_wctrl, i_wdata, i_ren,
        output o_rctrl, o_rdata, o_rlast, o_empty, o_full, o_afull,
               o_level, o_overflow, o_underflow
    );

endinterface

// File: rtl/mac_fifo_ram.sv
// 1W/1R register array: enable-gated synchronous write, asynchronous read, no reset.
module mac_fifo_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 37
) (
    input  logic                     clk,
    input  logic                     clk_en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clk_en && we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mac_tx_frame_fifo.sv
// Frame-aware TX FIFO: writes stay speculative until frame end, reads see committed
// frames only; abort rollback, overflow poison/drop, and underflow reporting.
module mac_tx_frame_fifo
    import mac_tx_frame_fifo_pkg::*;
#(
    parameter int unsigned N_CHANNELS   = MAC_N_CHANNELS,
    parameter int unsigned W_BYTE       = MAC_W_BYTE,
    parameter int unsigned DEPTH        = N_MAC_TX_FIFO,
    parameter int unsigned AFULL_THRESH = MAC_AFULL_THRESH
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_clk_en,
    input  logic                i_clr,
    mac_tx_frame_fifo_if.slave  bus
);

    localparam int unsigned W_DATA = N_CHANNELS * W_BYTE;
    localparam int unsigned W_WORD = 1 + N_CHANNELS + W_DATA;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned PW     = ptr_width(DEPTH);

    typedef logic [PW-1:0] ptr_t;

    typedef struct packed {
        logic                  last;
        logic [N_CHANNELS-1:0] ctrl;
        logic [W_DATA-1:0]     data;
    } lane_word_t;

    ptr_t       rptr_q, rptr_d;
    ptr_t       wspec_q, wspec_d;
    ptr_t       wcom_q, wcom_d;
    logic       poison_q, poison_d;
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;
    logic       ram_we;
    ptr_t       occ;
    logic       full;
    logic       empty;
    lane_word_t wword;
    lane_word_t rword;

    // Status derived only from registered pointers
    assign occ   = wspec_q - rptr_q;
    assign full  = (occ == PW'(DEPTH));
    assign empty = (wcom_q == rptr_q);

    assign wword.last = bus.i_wlast;
    assign wword.ctrl = bus.i_wctrl;
    assign wword.data = bus.i_wdata;

    mac_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (W_WORD)
    ) u_ram (
        .clk    (i_clk),
        .clk_en (i_clk_en),
        .we     (ram_we),
        .waddr  (wspec_q[AW-1:0]),
        .wdata  (wword),
        .raddr  (rptr_q[AW-1:0]),
        .rdata  (rword)
    );

    // Next-state: clear beats abort beats write; read side independent except on clear
    always_comb begin
        rptr_d   = rptr_q;
        wspec_d  = wspec_q;
        wcom_d   = wcom_q;
        poison_d = poison_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        ram_we   = 1'b0;

        if (i_clr) begin
            rptr_d   = '0;
            wspec_d  = '0;
            wcom_d   = '0;
            poison_d = 1'b0;
        end else begin
            if (bus.i_ren) begin
                if (empty) begin
                    unf_d = 1'b1;
                end else begin
                    rptr_d = rptr_q + PW'(1);
                end
            end

            if (bus.i_wabort) begin
                wspec_d  = wcom_q;
                poison_d = 1'b0;
            end else if (bus.i_wen) begin
                if (!full) begin
                    ram_we  = 1'b1;
                    wspec_d = wspec_q + PW'(1);
                    if (bus.i_wlast) begin
                        if (poison_q) begin
                            wspec_d  = wcom_q;
                            poison_d = 1'b0;
                        end else begin
                            wcom_d = wspec_q + PW'(1);
                        end
                    end
                end else begin
                    // Dropped word taints the frame; its last word discards it whole
                    ovf_d = 1'b1;
                    if (bus.i_wlast) begin
                        wspec_d  = wcom_q;
                        poison_d = 1'b0;
                    end else begin
                        poison_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rptr_q   <= '0;
            wspec_q  <= '0;
            wcom_q   <= '0;
            poison_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (i_clk_en) begin
            rptr_q   <= rptr_d;
            wspec_q  <= wspec_d;
            wcom_q   <= wcom_d;
            poison_q <= poison_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign bus.o_rlast     = rword.last;
    assign bus.o_rctrl     = rword.ctrl;
    assign bus.o_rdata     = rword.data;
    assign bus.o_empty     = empty;
    assign bus.o_full      = full;
    assign bus.o_afull     = (occ >= PW'(AFULL_THRESH));
    assign bus.o_level     = wcom_q - rptr_q;
    assign bus.o_overflow  = ovf_q;
    assign bus.o_underflow = unf_q;

endmodule

// File: tb/tb_mac_tx_frame_fifo.sv
// Self-checking bench for mac_tx_frame_fifo (DEPTH=8, AFULL_THRESH=6) against a
// queue-based frame model.
module tb_mac_tx_frame_fifo;
    import mac_tx_frame_fifo_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AFULL = 6;

    logic clk = 1'b0;
    logic rst_n;
    logic clk_en;
    logic clr;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mac_tx_frame_fifo_if #(.N_CHANNELS(4), .W_BYTE(8), .DEPTH(DEPTH)) bus ();

    mac_tx_frame_fifo #(
        .N_CHANNELS   (4),
        .W_BYTE       (8),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_clk_en  (clk_en),
        .i_clr     (clr),
        .bus       (bus)
    );

    // Model: committed words, words of the frame in progress, poison flag, pulses
    mac_lane_word_t m_com[$];
    mac_lane_word_t m_spec[$];
    bit m_poison, m_ovf, m_unf;

    task automatic model_reset();
        m_com.delete();
        m_spec.delete();
        m_poison = 0;
        m_ovf    = 0;
        m_unf    = 0;
    endtask

    task automatic model_step(input bit en, input bit c, input bit wen, input bit wlast,
                              input bit wabort, input bit ren, input mac_lane_word_t w);
        int occ;
        bit full;
        bit empty;
        if (!en) return;
        if (c) begin
            model_reset();
            return;
        end
        occ   = m_com.size() + m_spec.size();
        full  = (occ == DEPTH);
        empty = (m_com.size() == 0);
        m_unf = ren && empty;
        if (ren && !empty) void'(m_com.pop_front());
        m_ovf = 0;
        if (wabort) begin
            m_spec.delete();
            m_poison = 0;
        end else if (wen) begin
            if (!full) begin
                m_spec.push_back(w);
                if (wlast) begin
                    if (!m_poison) foreach (m_spec[i]) m_com.push_back(m_spec[i]);
                    m_spec.delete();
                    m_poison = 0;
                end
            end else begin
                m_ovf = 1;
                if (wlast) begin
                    m_spec.delete();
                    m_poison = 0;
                end else begin
                    m_poison = 1;
                end
            end
        end
    endtask

    // One clock: drive, take the edge, advance the model, settle 1 time unit past the edge
    task automatic cyc(input bit en, input bit c, input bit wen, input bit wlast,
                       input bit wabort, input bit ren, input logic [3:0] ctrl,
                       input logic [31:0] data);
        mac_lane_word_t w;
        w.last       = wlast;
        w.ctrl       = ctrl;
        w.data       = data;
        clk_en       = en;
        clr          = c;
        bus.i_wen    = wen;
        bus.i_wlast  = wlast;
        bus.i_wabort = wabort;
        bus.i_ren    = ren;
        bus.i_wctrl  = ctrl;
        bus.i_wdata  = data;
        @(posedge clk);
        model_step(en, c, wen, wlast, wabort, ren, w);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clk_en = 1'b1; clr = 1'b0;
        bus.i_wen = 0; bus.i_wlast = 0; bus.i_wabort = 0; bus.i_ren = 0;
        bus.i_wctrl = '0; bus.i_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (bus.o_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", bus.o_empty); end
        vectors++; if (bus.o_full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", bus.o_full); end
        vectors++; if (bus.o_afull !== 1'b0) begin miscompares++; $display("FAIL reset_afull got %b want 0", bus.o_afull); end
        vectors++; if (bus.o_level !== 4'd0) begin miscompares++; $display("FAIL reset_level got %0d want 0", bus.o_level); end
        vectors++; if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin
            miscompares++; $display("FAIL reset_pulses got %b%b want 00", bus.o_overflow, bus.o_underflow); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_frame();
        logic [31:0] d [3];
        d[0] = 32'h11111111; d[1] = 32'h22222222; d[2] = 32'h33333333;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 1, i == 2, 0, 0, 4'(i), d[i]);
            if (i < 2) begin
                vectors++; if (bus.o_empty !== 1'b1) begin miscompares++; $display("FAIL basic_empty_w%0d got %b want 1", i, bus.o_empty); end
            end
        end
        vectors++; if (bus.o_level !== 4'd3) begin miscompares++; $display("FAIL basic_level got %0d want 3", bus.o_level); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (bus.o_rdata !== d[i] || bus.o_rctrl !== 4'(i) || bus.o_rlast !== (i == 2)) begin
                miscompares++; $display("FAIL basic_read%0d got %h/%h/%b want %h/%h/%b", i, bus.o_rdata, bus.o_rctrl, bus.o_rlast, d[i], 4'(i), (i == 2)); end
            cyc(1, 0, 0, 0, 0, 1, 4'h0, 32'h0);
        end
        vectors++; if (bus.o_empty !== 1'b1) begin miscompares++; $display("FAIL basic_drained got %b want 1", bus.o_empty); end
    endtask

    task automatic test_abort();
        cyc(1, 0, 1, 0, 0, 0, 4'h1, 32'hDEADBEEF);
        cyc(1, 0, 1, 0, 0, 0, 4'h2, 32'hCAFEF00D);
        cyc(1, 0, 1, 1, 1, 0, 4'h3, 32'hBADBADBA);
        cyc(1, 0, 1, 1, 0, 0, 4'hF, 32'hAAAAAAAA);
        vectors++; if (bus.o_level !== 4'd1) begin miscompares++; $display("FAIL abort_level got %0d want 1", bus.o_level); end
        vectors++; if (bus.o_rdata !== 32'hAAAAAAAA || bus.o_rlast !== 1'b1) begin
            miscompares++; $display("FAIL abort_data got %h/%b want aaaaaaaa/1", bus.o_rdata, bus.o_rlast); end
        cyc(1, 0, 0, 0, 0, 1, 4'h0, 32'h0);
        vectors++; if (bus.o_empty !== 1'b1 || bus.o_underflow !== 1'b0) begin
            miscompares++; $display("FAIL abort_drained got %b/%b want 1/0", bus.o_empty, bus.o_underflow); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) begin
            cyc(1, 0, 1, i == 9, 0, 0, 4'(i), $urandom);
            if (i <= 8) begin
                vectors++; if (bus.o_afull !== (i >= 6) || bus.o_full !== (i >= 8) || bus.o_empty !== 1'b1) begin
                    miscompares++; $display("FAIL ovf_status_w%0d got af=%b f=%b e=%b want af=%b f=%b e=1", i, bus.o_afull, bus.o_full, bus.o_empty, (i >= 6), (i >= 8)); end
            end
        end
        vectors++; if (bus.o_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_pulse got %b want 1", bus.o_overflow); end
        vectors++; if (bus.o_empty !== 1'b1 || bus.o_full !== 1'b0 || bus.o_level !== 4'd0 || bus.o_afull !== 1'b0) begin
            miscompares++; $display("FAIL ovf_dropped got e=%b f=%b af=%b lvl=%0d want 1 0 0 0", bus.o_empty, bus.o_full, bus.o_afull, bus.o_level); end
        cyc(1, 0, 0, 0, 0, 0, 4'h0, 32'h0);
        vectors++; if (bus.o_overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_pulse_end got %b want 0", bus.o_overflow); end
    endtask

    task automatic test_back_to_back();
        mac_lane_word_t exp[$];
        mac_lane_word_t got;
        logic [31:0] d;
        logic [3:0]  c;
        bit rd;
        int guard;
        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < 5; k++) begin
                d = $urandom;
                c = 4'($urandom_range(0, 15));
                exp.push_back({k == 4, c, d});
                rd = !bus.o_empty;
                if (rd) begin
                    got = {bus.o_rlast, bus.o_rctrl, bus.o_rdata};
                    vectors++; if (exp.size() == 0 || got !== exp[0]) begin
                        miscompares++; $display("FAIL b2b_word f%0d k%0d got %h want %h", f, k, got, exp[0]); end
                    void'(exp.pop_front());
                end
                cyc(1, 0, 1, k == 4, 0, rd, c, d);
                vectors++; if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin
                    miscompares++; $display("FAIL b2b_pulse f%0d k%0d got ovf=%b unf=%b want 0 0", f, k, bus.o_overflow, bus.o_underflow); end
            end
        end
        guard = 0;
        while (exp.size() != 0 && guard < 50) begin
            if (!bus.o_empty) begin
                got = {bus.o_rlast, bus.o_rctrl, bus.o_rdata};
                vectors++; if (got !== exp[0]) begin
                    miscompares++; $display("FAIL b2b_drain got %h want %h", got, exp[0]); end
                void'(exp.pop_front());
            end
            cyc(1, 0, 0, 0, 0, !bus.o_empty, 4'h0, 32'h0);
            guard++;
        end
        vectors++; if (exp.size() != 0 || bus.o_empty !== 1'b1) begin
            miscompares++; $display("FAIL b2b_complete got %0d left empty=%b want 0 left empty=1", exp.size(), bus.o_empty); end
    endtask

    task automatic test_random();
        int occ;
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0, $urandom_range(0, 9) < 6,
                $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1,
                4'($urandom_range(0, 15)), $urandom);
            occ = m_com.size() + m_spec.size();
            vectors++; if (bus.o_empty !== (m_com.size() == 0) || bus.o_level !== 4'(m_com.size())) begin
                miscompares++; $display("FAIL rnd_level n%0d got e=%b lvl=%0d want e=%b lvl=%0d", n, bus.o_empty, bus.o_level, (m_com.size() == 0), m_com.size()); end
            vectors++; if (bus.o_full !== (occ == DEPTH) || bus.o_afull !== (occ >= AFULL)) begin
                miscompares++; $display("FAIL rnd_occ n%0d got f=%b af=%b want occ=%0d", n, bus.o_full, bus.o_afull, occ); end
            vectors++; if (bus.o_overflow !== m_ovf || bus.o_underflow !== m_unf) begin
                miscompares++; $display("FAIL rnd_pulse n%0d got ovf=%b unf=%b want %b %b", n, bus.o_overflow, bus.o_underflow, m_ovf, m_unf); end
            if (m_com.size() != 0) begin
                vectors++; if ({bus.o_rlast, bus.o_rctrl, bus.o_rdata} !== m_com[0]) begin
                    miscompares++; $display("FAIL rnd_data n%0d got %h want %h", n, {bus.o_rlast, bus.o_rctrl, bus.o_rdata}, m_com[0]); end
            end
        end
        cyc(1, 1, 0, 0, 0, 0, 4'h0, 32'h0);
    endtask

    task automatic test_clk_en_clr();
        cyc(1, 0, 1, 0, 0, 0, 4'h1, 32'h01020304);
        cyc(1, 0, 1, 1, 0, 0, 4'h2, 32'h05060708);
        cyc(1, 0, 1, 0, 0, 0, 4'h3, 32'h090A0B0C);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 1, 0, 1, 4'h4, 32'hFFFFFFFF);
            vectors++; if (bus.o_level !== 4'd2 || bus.o_rdata !== 32'h01020304 || bus.o_afull !== 1'b0) begin
                miscompares++; $display("FAIL cken_frozen c%0d got lvl=%0d d=%h af=%b want 2 01020304 0", i, bus.o_level, bus.o_rdata, bus.o_afull); end
        end
        cyc(1, 1, 1, 1, 0, 1, 4'h5, 32'h12345678);
        vectors++; if (bus.o_empty !== 1'b1 || bus.o_level !== 4'd0 || bus.o_full !== 1'b0) begin
            miscompares++; $display("FAIL clr_state got e=%b lvl=%0d f=%b want 1 0 0", bus.o_empty, bus.o_level, bus.o_full); end
        cyc(1, 0, 1, 1, 0, 0, 4'hA, 32'h5A5A5A5A);
        vectors++; if (bus.o_level !== 4'd1 || bus.o_rdata !== 32'h5A5A5A5A || bus.o_rctrl !== 4'hA) begin
            miscompares++; $display("FAIL clr_next_frame got lvl=%0d d=%h c=%h want 1 5a5a5a5a a", bus.o_level, bus.o_rdata, bus.o_rctrl); end
        cyc(1, 0, 0, 0, 0, 1, 4'h0, 32'h0);
    endtask

    task automatic test_underflow_async();
        cyc(1, 0, 0, 0, 0, 1, 4'h0, 32'h0);
        vectors++; if (bus.o_underflow !== 1'b1 || bus.o_empty !== 1'b1) begin
            miscompares++; $display("FAIL unf_pulse got unf=%b e=%b want 1 1", bus.o_underflow, bus.o_empty); end
        cyc(0, 0, 0, 0, 0, 0, 4'h0, 32'h0);
        vectors++; if (bus.o_underflow !== 1'b1) begin miscompares++; $display("FAIL unf_hold got %b want 1", bus.o_underflow); end
        cyc(1, 0, 0, 0, 0, 0, 4'h0, 32'h0);
        vectors++; if (bus.o_underflow !== 1'b0) begin miscompares++; $display("FAIL unf_end got %b want 0", bus.o_underflow); end
        cyc(1, 0, 1, 1, 0, 0, 4'h7, 32'h77777777);
        vectors++; if (bus.o_level !== 4'd1 || bus.o_rdata !== 32'h77777777) begin
            miscompares++; $display("FAIL unf_rptr got lvl=%0d d=%h want 1 77777777", bus.o_level, bus.o_rdata); end
        cyc(1, 0, 1, 0, 0, 0, 4'h8, 32'h88888888);
        cyc(1, 0, 1, 0, 0, 0, 4'h9, 32'h99999999);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        vectors++; if (bus.o_empty !== 1'b1 || bus.o_level !== 4'd0 || bus.o_full !== 1'b0 || bus.o_afull !== 1'b0) begin
            miscompares++; $display("FAIL async_reset got e=%b lvl=%0d f=%b af=%b want 1 0 0 0", bus.o_empty, bus.o_level, bus.o_full, bus.o_afull); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 1, 1, 0, 0, 4'hC, 32'hC3C3C3C3);
        vectors++; if (bus.o_level !== 4'd1 || bus.o_rdata !== 32'hC3C3C3C3 || bus.o_rlast !== 1'b1) begin
            miscompares++; $display("FAIL post_reset_frame got lvl=%0d d=%h l=%b want 1 c3c3c3c3 1", bus.o_level, bus.o_rdata, bus.o_rlast); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_abort();
        test_overflow();
        test_back_to_back();
        test_random();
        test_clk_en_clr();
        test_underflow_async();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
